// File: rtl/fft_pkg.sv
// Shared FFT datapath definitions.
//   FFT_DATA_WIDTH : default sample width (signed)
//   FFT_N_POINTS   : default samples per frame
//   grp_w()        : width of a 4-sample group index for a given frame size
//   lane_e         : lane index A..D, common to the 1x4 demux and 4x1 select
package fft_pkg;

    localparam int unsigned FFT_DATA_WIDTH = 32;
    localparam int unsigned FFT_N_POINTS   = 32;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

    // Group index width, never narrower than one bit.
    function automatic int unsigned grp_w(input int unsigned n_points);
        int unsigned w;
        w = $clog2(n_points / 4);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_group_counter.sv
// Wrapping modulo-MODULUS counter with increment enable.
//   clk, rst : clock, synchronous active-high reset (count -> 0)
//   inc_en   : advance by one, wrapping to 0 after MODULUS-1
//   count    : current value
//   last     : count == MODULUS-1
module frame_group_counter #(
    parameter int unsigned MODULUS = 8,
    parameter int unsigned CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        last    = (count_q == CNT_W'(MODULUS - 1));
        count_d = count_q;
        if (inc_en) begin
            count_d = last ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stream_demux_1x4.sv
// Serial-to-parallel distributor: steers consecutive signed samples into
// lanes A..D and presents each completed group on a valid/ready interface.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input sample handshake, in_data the sample
//   out_valid/out_ready : group handshake
//   out_A..out_D      : samples 4k..4k+3 of the frame
//   out_grp           : group index k, out_last high when k == N_POINTS/4-1
// in_ready depends combinationally on out_ready; out_* are fully registered.
module stream_demux_1x4
    import fft_pkg::*;
#(
    parameter int unsigned data_width = FFT_DATA_WIDTH,
    parameter int unsigned N_POINTS   = FFT_N_POINTS,
    parameter int unsigned GRP_W      = grp_w(N_POINTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [data_width-1:0] in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [data_width-1:0] out_A,
    output logic signed [data_width-1:0] out_B,
    output logic signed [data_width-1:0] out_C,
    output logic signed [data_width-1:0] out_D,
    output logic [GRP_W-1:0]             out_grp,
    output logic                         out_last
);

    lane_e                         sel_q, sel_d;
    logic signed [data_width-1:0]  collect_q [3];
    logic signed [data_width-1:0]  collect_d [3];
    logic signed [data_width-1:0]  out_a_q, out_a_d;
    logic signed [data_width-1:0]  out_b_q, out_b_d;
    logic signed [data_width-1:0]  out_c_q, out_c_d;
    logic signed [data_width-1:0]  out_d_q, out_d_d;
    logic [GRP_W-1:0]              out_grp_q, out_grp_d;
    logic                          out_last_q, out_last_d;
    logic                          out_valid_q, out_valid_d;

    logic                          in_fire;
    logic                          load;
    logic [GRP_W-1:0]              grp_count;
    logic                          grp_last;

    frame_group_counter #(
        .MODULUS (N_POINTS / 4),
        .CNT_W   (GRP_W)
    ) u_grp_cnt (
        .clk    (clk),
        .rst    (rst),
        .inc_en (load),
        .count  (grp_count),
        .last   (grp_last)
    );

    always_comb begin
        // Stall only when the 4th sample would overwrite an unconsumed group.
        in_ready = !(sel_q == LANE_D && out_valid_q && !out_ready);
        in_fire  = in_valid && in_ready;
        load     = in_fire && (sel_q == LANE_D);

        sel_d       = sel_q;
        collect_d   = collect_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        out_c_d     = out_c_q;
        out_d_d     = out_d_q;
        out_grp_d   = out_grp_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;

        if (in_fire) begin
            unique case (sel_q)
                LANE_A: begin collect_d[0] = in_data; sel_d = LANE_B; end
                LANE_B: begin collect_d[1] = in_data; sel_d = LANE_C; end
                LANE_C: begin collect_d[2] = in_data; sel_d = LANE_D; end
                LANE_D: sel_d = LANE_A;
                default: sel_d = LANE_A;
            endcase
        end

        // A load in the same cycle as a consume keeps out_valid high.
        if (load) begin
            out_a_d     = collect_q[0];
            out_b_d     = collect_q[1];
            out_c_d     = collect_q[2];
            out_d_d     = in_data;
            out_grp_d   = grp_count;
            out_last_d  = grp_last;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= LANE_A;
            collect_q   <= '{default: '0};
            out_a_q     <= '0;
            out_b_q     <= '0;
            out_c_q     <= '0;
            out_d_q     <= '0;
            out_grp_q   <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            collect_q   <= collect_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            out_c_q     <= out_c_d;
            out_d_q     <= out_d_d;
            out_grp_q   <= out_grp_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_A     = out_a_q;
    assign out_B     = out_b_q;
    assign out_C     = out_c_q;
    assign out_D     = out_d_q;
    assign out_grp   = out_grp_q;
    assign out_last  = out_last_q;

endmodule

// File: doc/stream_demux_1x4.md
Name: stream_demux_1x4

Overview:
- Serial-to-parallel distributor, the counterpart of the 4-to-1 select path in the FFT datapath.
- Accepts one signed sample per handshake and steers consecutive samples into four lanes A, B, C, D.
- Presents each completed 4-sample group to the radix-4/butterfly input stage on a valid/ready interface.
- Tracks group position within a frame of N_POINTS samples and flags the last group.

Parameters:
- data_width, 32, sample width in bits (signed).
- N_POINTS, 32, samples per FFT frame; must be a multiple of 4, minimum 4.
- GRP_W, $clog2(N_POINTS/4) (minimum 1), width of the group index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  data_width  signed input sample.
- out_valid  out  1  4-lane group valid.
- out_ready  in  1  downstream accepts group.
- out_A, out_B, out_C, out_D  out  data_width each  lanes holding samples 4k, 4k+1, 4k+2, 4k+3 of the frame.
- out_grp  out  GRP_W  group index k within the frame.
- out_last  out  1  high with out_valid when k == N_POINTS/4-1.

Behaviour:
- Reset (rst=1 at a clk edge) values:
  - lane select counter sel = 0, group counter grp = 0.
  - out_valid = 0, out_last = 0, out_grp = 0, out_A..out_D = 0.
  - Collect registers = 0. in_ready = 1 after reset.
  - Reset mid-group discards any partial samples; no partial group is ever emitted.
- Input handshake: a sample transfers when in_valid && in_ready at clk.
  - sel 0/1/2: sample is written to collect register 0/1/2, then sel increments.
  - sel 3: collect[0..2] and in_data load out_A..out_D together. out_grp <= grp, out_last <= (grp == N_POINTS/4-1), out_valid <= 1, sel wraps to 0, and grp increments, wrapping to 0 after N_POINTS/4-1.
- Output handshake: a group is consumed when out_valid && out_ready. out_valid then clears unless a new group loads in the same cycle.
- Data stability: out_* are stable while out_valid && !out_ready.
- in_ready = !(sel == 3 && out_valid && !out_ready).
  - Input stalls only when the 4th sample would overwrite an unconsumed group.
  - Samples for sel 0..2 are always accepted.
- Simultaneous consume and load (sel==3 input handshake and output handshake in one cycle): the new group loads and out_valid stays 1. Full throughput is 1 sample/cycle with no bubbles.
- Latency: the group is visible on out_* the cycle after its 4th sample transfers.
- No combinational path from in_data to out_*. in_ready depends combinationally on out_ready (documented; downstream must not feed in_ready back into out_ready).
- in_data is ignored when in_valid=0. No arithmetic is performed: sample values pass bit-exact, sign preserved.

Decomposition:
- Shared package fft_pkg: data_width default, N_POINTS, a GRP_W helper function, and a lane-index enum LANE_A..LANE_D (2 bits) shared with the 4x1 select logic.
- One natural sub-module: frame_group_counter, a wrapping modulo-N_POINTS/4 counter with an increment enable and a last flag. It is reusable by the output reorder stage.

Test Plan:
1. Reset then stream samples 1..8 with in_valid=1 and out_ready=1:
   - group 0 has out_A..D = 1,2,3,4, out_grp=0, appearing the cycle after sample 4.
   - group 1 has 5,6,7,8, out_grp=1.
   - in_ready stays 1 throughout.
2. Backpressure: out_ready=0 after the first group is formed, keep streaming.
   - Samples 5,6,7 are accepted.
   - in_ready=0 while sample 8 is presented; out_* hold 1,2,3,4.
   - Raising out_ready consumes group 0 and loads 5..8 in that same cycle.
3. Full frame N_POINTS=32 with samples -16..15 (signed):
   - out_last=1 only on out_grp=7, with lanes 12,13,14,15.
   - Negative values are reproduced bit-exact.
   - The next frame starts at out_grp=0.
4. Gapped input: in_valid toggles 1/0 over samples 10,20,30,40 → a single group 10,20,30,40 is emitted, with no duplicates and no drops.
5. Reset after 2 samples (7, 9), then feed 1,2,3,4:
   - No group containing 7 or 9 is emitted.
   - The output is 1,2,3,4 with out_grp=0, and out_valid=0 during reset.
6. Randomized valid/ready for 4 frames: scoreboard confirms in-order lane mapping and out_grp sequence 0..7 repeated, with no data held while out_valid && !out_ready changes.
